// File: rtl/f9pcap_eth_mux.sv
// f9pcap_eth_mux -- merges CH_COUNT framed beat streams onto one output.
// A two-state FSM grants one channel per frame (round-robin or fixed
// priority), passes that channel's beats straight through until its last
// beat is accepted, then re-arbitrates after a single idle cycle.
//
//   state | meaning
//   IDLE  | no grant active; arbitrate among requesting channels
//   XFER  | granted channel's beats pass through until last beat accepted
//
// Ports:
//   clk_in, rst_n_in            clock, async active-low reset
//   i_valid_in/i_ready_out      per-channel handshake
//   i_data_in/i_keep_in/i_last_in/i_data_len_in   per-channel beat fields
//   o_valid_out/o_ready_in      merged handshake
//   o_data_out/o_keep_out/o_last_out              merged beat
//   o_data_len_out/o_ch_id_out  length and index of the granted frame
//   frame_cnt_out               per-channel completed-frame counters
//   busy_out                    high in XFER
module f9pcap_eth_mux #(
   parameter int CH_COUNT   = 4,
   parameter int DATA_WIDTH = 64,
   parameter int ARB_MODE   = 0,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                                    clk_in,
   input  logic                                    rst_n_in,
   input  logic [CH_COUNT-1:0]                     i_valid_in,
   output logic [CH_COUNT-1:0]                     i_ready_out,
   input  logic [CH_COUNT*DATA_WIDTH-1:0]          i_data_in,
   input  logic [CH_COUNT*(DATA_WIDTH/8)-1:0]      i_keep_in,
   input  logic [CH_COUNT-1:0]                     i_last_in,
   input  logic [CH_COUNT*16-1:0]                  i_data_len_in,
   output logic                                    o_valid_out,
   input  logic                                    o_ready_in,
   output logic [DATA_WIDTH-1:0]                   o_data_out,
   output logic [DATA_WIDTH/8-1:0]                 o_keep_out,
   output logic                                    o_last_out,
   output logic [15:0]                             o_data_len_out,
   output logic [((CH_COUNT > 1) ? $clog2(CH_COUNT) : 1)-1:0] o_ch_id_out,
   output logic [CH_COUNT*CNT_WIDTH-1:0]           frame_cnt_out,
   output logic                                    busy_out
);

   localparam int KEEP_WIDTH  = DATA_WIDTH / 8;
   localparam int CH_ID_WIDTH = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [CH_ID_WIDTH-1:0]  r_grant;
   logic [CH_ID_WIDTH-1:0]  r_last_grant;
   logic [15:0]             r_len;
   logic [CNT_WIDTH-1:0]    r_cnt [CH_COUNT];

   logic                    w_any;
   logic [CH_ID_WIDTH-1:0]  w_pick;
   logic [15:0]             w_pick_len;
   logic                    w_sel_valid;
   logic                    w_sel_last;
   logic [DATA_WIDTH-1:0]   w_sel_data;
   logic [KEEP_WIDTH-1:0]   w_sel_keep;
   logic                    w_busy;
   logic                    w_done;

   // Arbiter. Loops run from the lowest-preference candidate to the highest
   // so the last matching assignment is the winner, with no found-flag.
   always_comb begin
      w_any  = |i_valid_in;
      w_pick = '0;
      if (ARB_MODE == 1) begin
         for (int i = CH_COUNT - 1; i >= 0; i--) begin
            if (i_valid_in[i]) w_pick = CH_ID_WIDTH'(i);
         end
      end else begin
         for (int k = CH_COUNT; k >= 1; k--) begin
            if (i_valid_in[(int'(r_last_grant) + k) % CH_COUNT])
               w_pick = CH_ID_WIDTH'((int'(r_last_grant) + k) % CH_COUNT);
         end
      end
   end

   always_comb begin
      w_pick_len  = '0;
      w_sel_valid = 1'b0;
      w_sel_last  = 1'b0;
      w_sel_data  = '0;
      w_sel_keep  = '0;
      for (int i = 0; i < CH_COUNT; i++) begin
         if (w_pick == CH_ID_WIDTH'(i))
            w_pick_len = i_data_len_in[i*16 +: 16];
         if (r_grant == CH_ID_WIDTH'(i)) begin
            w_sel_valid = i_valid_in[i];
            w_sel_last  = i_last_in[i];
            w_sel_data  = i_data_in[i*DATA_WIDTH +: DATA_WIDTH];
            w_sel_keep  = i_keep_in[i*KEEP_WIDTH +: KEEP_WIDTH];
         end
      end
   end

   assign w_busy      = (r_state == ST_XFER);
   assign o_valid_out = w_busy & w_sel_valid;
   assign o_last_out  = w_busy & w_sel_last;
   assign o_data_out  = w_sel_data;
   assign o_keep_out  = w_sel_keep;
   assign w_done      = o_valid_out & o_ready_in & o_last_out;

   always_comb begin
      i_ready_out = '0;
      for (int i = 0; i < CH_COUNT; i++) begin
         i_ready_out[i] = w_busy && (r_grant == CH_ID_WIDTH'(i)) && o_ready_in;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_any)  w_state_nxt = ST_XFER;
         ST_XFER: if (w_done) w_state_nxt = ST_IDLE;
         default:             w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state      <= ST_IDLE;
         r_grant      <= '0;
         r_last_grant <= CH_ID_WIDTH'(CH_COUNT - 1);
         r_len        <= '0;
         for (int i = 0; i < CH_COUNT; i++) r_cnt[i] <= '0;
      end else begin
         r_state <= w_state_nxt;
         // Grant and length are captured only at frame start, which is what
         // keeps them frozen for the whole frame.
         if (r_state == ST_IDLE && w_any) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
            r_len        <= w_pick_len;
         end
         for (int i = 0; i < CH_COUNT; i++) begin
            if (w_done && r_grant == CH_ID_WIDTH'(i)) r_cnt[i] <= r_cnt[i] + 1'b1;
         end
      end
   end

   for (genvar g = 0; g < CH_COUNT; g++) begin : g_cnt
      assign frame_cnt_out[g*CNT_WIDTH +: CNT_WIDTH] = r_cnt[g];
   end

   assign o_data_len_out = r_len;
   assign o_ch_id_out    = r_grant;
   assign busy_out       = w_busy;

endmodule

// File: tb/tb_f9pcap_eth_mux.sv
// Self-checking bench for f9pcap_eth_mux: a round-robin instance with 4-bit
// counters and a fixed-priority instance share one stimulus.
module tb_f9pcap_eth_mux;

   localparam int CH = 4;
   localparam int DW = 16;
   localparam int KW = 2;

   logic            clk_in = 1'b0;
   logic            rst_n_in;
   logic [CH-1:0]   i_valid;
   logic [CH*DW-1:0] i_data;
   logic [CH*KW-1:0] i_keep;
   logic [CH-1:0]   i_last;
   logic [CH*16-1:0] i_len;
   logic            o_ready;

   logic [CH-1:0]   rr_iready, fp_iready;
   logic            rr_ovalid, fp_ovalid, rr_olast, fp_olast, rr_busy, fp_busy;
   logic [DW-1:0]   rr_data, fp_data;
   logic [KW-1:0]   rr_keep, fp_keep;
   logic [15:0]     rr_len, fp_len;
   logic [1:0]      rr_ch, fp_ch;
   logic [CH*4-1:0] rr_cnt;
   logic [CH*32-1:0] fp_cnt;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk_in = ~clk_in;

   f9pcap_eth_mux #(.CH_COUNT(CH), .DATA_WIDTH(DW), .ARB_MODE(0), .CNT_WIDTH(4)) dut_rr (
      .clk_in(clk_in), .rst_n_in(rst_n_in),
      .i_valid_in(i_valid), .i_ready_out(rr_iready), .i_data_in(i_data),
      .i_keep_in(i_keep), .i_last_in(i_last), .i_data_len_in(i_len),
      .o_valid_out(rr_ovalid), .o_ready_in(o_ready), .o_data_out(rr_data),
      .o_keep_out(rr_keep), .o_last_out(rr_olast), .o_data_len_out(rr_len),
      .o_ch_id_out(rr_ch), .frame_cnt_out(rr_cnt), .busy_out(rr_busy));

   f9pcap_eth_mux #(.CH_COUNT(CH), .DATA_WIDTH(DW), .ARB_MODE(1), .CNT_WIDTH(32)) dut_fp (
      .clk_in(clk_in), .rst_n_in(rst_n_in),
      .i_valid_in(i_valid), .i_ready_out(fp_iready), .i_data_in(i_data),
      .i_keep_in(i_keep), .i_last_in(i_last), .i_data_len_in(i_len),
      .o_valid_out(fp_ovalid), .o_ready_in(o_ready), .o_data_out(fp_data),
      .o_keep_out(fp_keep), .o_last_out(fp_olast), .o_data_len_out(fp_len),
      .o_ch_id_out(fp_ch), .frame_cnt_out(fp_cnt), .busy_out(fp_busy));

   typedef struct {
      logic [3:0] valid;
      logic [3:0] last;
      logic       rdy;
      logic       busy;
      logic [1:0] ch;
      logic       ovalid;
      logic       olast;
      logic [3:0] iready;
   } vec_t;

   logic [1:0] kv [CH];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic set_defaults();
      for (int c = 0; c < CH; c++) begin
         i_data[c*DW +: DW] = 16'hC000 + 16'(c);
         i_len[c*16 +: 16]  = 16'(10 + 8 * c);
      end
      i_keep = {kv[3], kv[2], kv[1], kv[0]};
   endtask

   task automatic do_reset();
      rst_n_in = 1'b0;
      i_valid  = '0;
      i_last   = '0;
      o_ready  = 1'b1;
      repeat (2) @(posedge clk_in);
      #1;
      rst_n_in = 1'b1;
   endtask

   initial begin
      vec_t tbl[12];
      int b[CH];
      int grants[5];
      int entry[5];
      int ng, cyc, beat, p;
      logic prev_busy;
      logic [3:0] hs;

      kv[0] = 2'b01; kv[1] = 2'b10; kv[2] = 2'b11; kv[3] = 2'b01;
      tbl[0]  = '{4'b0101, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000};
      tbl[1]  = '{4'b0101, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0001};
      tbl[2]  = '{4'b0101, 4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 4'b0000};
      tbl[3]  = '{4'b0101, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 4'b0001};
      tbl[4]  = '{4'b0101, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000};
      tbl[5]  = '{4'b0101, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 4'b0100};
      tbl[6]  = '{4'b0101, 4'b0000, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 4'b0000};
      tbl[7]  = '{4'b0101, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 4'b0001};
      tbl[8]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000};
      tbl[9]  = '{4'b1000, 4'b1000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000};
      tbl[10] = '{4'b1000, 4'b1000, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 4'b1000};
      tbl[11] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 4'b0000};

      set_defaults();
      do_reset();

      // reset state
      #1;
      chk("rst_busy", 32'(rr_busy), 32'd0);
      chk("rst_ovalid", 32'(rr_ovalid), 32'd0);
      chk("rst_iready", 32'(rr_iready), 32'd0);
      chk("rst_len", 32'(rr_len), 32'd0);
      chk("rst_ch", 32'(rr_ch), 32'd0);
      chk("rst_cnt_rr", 32'(rr_cnt), 32'd0);
      chk("rst_cnt_fp0", fp_cnt[31:0], 32'd0);
      tick();

      // table-driven round-robin walk
      for (int r = 0; r < 12; r++) begin
         i_valid = tbl[r].valid;
         i_last  = tbl[r].last;
         o_ready = tbl[r].rdy;
         #1;
         chk($sformatf("tbl%0d_busy", r), 32'(rr_busy), 32'(tbl[r].busy));
         chk($sformatf("tbl%0d_ch", r), 32'(rr_ch), 32'(tbl[r].ch));
         chk($sformatf("tbl%0d_ovalid", r), 32'(rr_ovalid), 32'(tbl[r].ovalid));
         chk($sformatf("tbl%0d_olast", r), 32'(rr_olast), 32'(tbl[r].olast));
         chk($sformatf("tbl%0d_iready", r), 32'(rr_iready), 32'(tbl[r].iready));
         if (tbl[r].busy) begin
            chk($sformatf("tbl%0d_data", r), 32'(rr_data), 32'(16'hC000 + 16'(tbl[r].ch)));
            chk($sformatf("tbl%0d_keep", r), 32'(rr_keep), 32'(kv[tbl[r].ch]));
            chk($sformatf("tbl%0d_len", r), 32'(rr_len), 32'(10 + 8 * int'(tbl[r].ch)));
         end
         tick();
      end
      chk("tbl_cnt0", 32'(rr_cnt[3:0]), 32'd2);
      chk("tbl_cnt1", 32'(rr_cnt[7:4]), 32'd0);
      chk("tbl_cnt2", 32'(rr_cnt[11:8]), 32'd1);
      chk("tbl_cnt3", 32'(rr_cnt[15:12]), 32'd1);

      // round-robin, all channels sending 3-beat frames
      do_reset();
      for (int c = 0; c < CH; c++) b[c] = 0;
      i_valid = 4'b1111;
      ng = 0; cyc = 0; prev_busy = 1'b0;
      while (ng < 5 && cyc < 100) begin
         for (int c = 0; c < CH; c++) i_last[c] = (b[c] == 2);
         #1;
         if (rr_busy && !prev_busy) begin
            grants[ng] = int'(rr_ch);
            entry[ng]  = cyc;
            ng++;
            if (ng == 5) begin
               for (int c = 0; c < CH; c++)
                  chk($sformatf("rr4_cnt%0d", c), 32'(rr_cnt[c*4 +: 4]), 32'd1);
            end
         end
         prev_busy = rr_busy;
         hs = rr_iready & i_valid;
         tick();
         for (int c = 0; c < CH; c++) if (hs[c]) b[c] = (b[c] == 2) ? 0 : b[c] + 1;
         cyc++;
      end
      chk("rr4_grants_seen", 32'(ng), 32'd5);
      for (int n = 0; n < ng; n++) begin
         chk($sformatf("rr4_grant%0d", n), 32'(grants[n]), 32'(n % 4));
         if (n > 0) chk($sformatf("rr4_spacing%0d", n), 32'(entry[n] - entry[n-1]), 32'd4);
      end

      // fixed priority: ch1 and ch3 request, ch0 joins mid-frame of ch1
      do_reset();
      i_valid = 4'b1010;
      i_last  = 4'b1000;
      tick();
      i_valid = 4'b1011;
      i_last  = 4'b1001;
      #1;
      chk("fp_first_busy", 32'(fp_busy), 32'd1);
      chk("fp_first_ch", 32'(fp_ch), 32'd1);
      chk("fp_first_iready", 32'(fp_iready), 32'b0010);
      tick();
      i_last = 4'b1011;
      #1;
      chk("fp_hold_ch", 32'(fp_ch), 32'd1);
      chk("fp_hold_olast", 32'(fp_olast), 32'd1);
      tick();
      i_valid = 4'b1001;
      #1;
      chk("fp_bubble1", 32'(fp_busy), 32'd0);
      tick();
      chk("fp_second_ch", 32'(fp_ch), 32'd0);
      chk("fp_second_iready", 32'(fp_iready), 32'b0001);
      tick();
      i_valid = 4'b1000;
      #1;
      chk("fp_bubble2", 32'(fp_busy), 32'd0);
      tick();
      chk("fp_third_ch", 32'(fp_ch), 32'd3);
      tick();
      i_valid = '0;
      #1;
      chk("fp_cnt0", fp_cnt[31:0], 32'd1);
      chk("fp_cnt1", fp_cnt[63:32], 32'd1);
      chk("fp_cnt2", fp_cnt[95:64], 32'd0);
      chk("fp_cnt3", fp_cnt[127:96], 32'd1);

      // channel 2, 5-beat frame, len 40, ready pattern 1,0,0,1,0,0...
      do_reset();
      i_len[47:32] = 16'd40;
      i_valid = 4'b0100;
      beat = 0; p = 0; cyc = 0;
      while (beat < 5 && cyc < 40) begin
         i_data[47:32] = 16'h2000 + 16'(beat);
         i_last = (beat == 4) ? 4'b0100 : 4'b0000;
         o_ready = (p % 3 == 0);
         #1;
         if (rr_busy) begin
            chk("stall_len", 32'(rr_len), 32'd40);
            chk("stall_ch", 32'(rr_ch), 32'd2);
            chk("stall_iready", 32'(rr_iready), o_ready ? 32'b0100 : 32'b0000);
            if (o_ready) begin
               chk($sformatf("stall_beat%0d", beat), 32'(rr_data), 32'(16'h2000 + 16'(beat)));
               beat++;
            end
            p++;
         end
         tick();
         cyc++;
      end
      chk("stall_beats_done", 32'(beat), 32'd5);
      i_valid = '0;
      o_ready = 1'b1;
      #1;
      chk("stall_end_busy", 32'(rr_busy), 32'd0);
      chk("stall_cnt2", 32'(rr_cnt[11:8]), 32'd1);
      set_defaults();

      // single-beat frames on channel 0 back-to-back
      do_reset();
      i_valid = 4'b0001;
      i_last  = 4'b0001;
      for (int c = 0; c < 8; c++) begin
         #1;
         chk($sformatf("single_busy%0d", c), 32'(rr_busy), 32'(c % 2));
         chk($sformatf("single_cnt%0d", c), 32'(rr_cnt[3:0]), 32'(c / 2));
         tick();
      end

      // reset pulsed at beat 2 of a 4-beat frame
      do_reset();
      i_valid = 4'b0001;
      i_last  = 4'b0000;
      tick();
      tick();
      tick();
      #1;
      chk("midrst_pre_busy", 32'(rr_busy), 32'd1);
      rst_n_in = 1'b0;
      #1;
      chk("midrst_busy", 32'(rr_busy), 32'd0);
      chk("midrst_ovalid", 32'(rr_ovalid), 32'd0);
      chk("midrst_iready", 32'(rr_iready), 32'd0);
      chk("midrst_len", 32'(rr_len), 32'd0);
      chk("midrst_cnt0", 32'(rr_cnt[3:0]), 32'd0);
      rst_n_in = 1'b1;
      i_valid = 4'b0011;
      i_last  = 4'b0011;
      tick();
      chk("midrst_regrant_busy", 32'(rr_busy), 32'd1);
      chk("midrst_regrant_ch", 32'(rr_ch), 32'd0);

      // 4-bit counter wrap: 17 frames on channel 1
      do_reset();
      i_valid = 4'b0010;
      i_last  = 4'b0010;
      repeat (32) tick();
      chk("wrap_cnt16", 32'(rr_cnt[7:4]), 32'd0);
      repeat (2) tick();
      chk("wrap_cnt17", 32'(rr_cnt[7:4]), 32'd1);
      chk("wrap_idle", 32'(rr_busy), 32'd0);
      i_valid = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
